// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: TX/RX byte FIFOs around a single-byte SPI master, with inter-byte gap and completion timeout
module spi_xfer_sequencer #(
    parameter int DEPTH          = 8,
    parameter int PTR_W          = 3,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             m_start,
    output logic [7:0]       m_tx_data,
    input  logic [7:0]       m_rx_data,
    input  logic             m_tx_valid,
    output logic             busy,
    output logic [PTR_W:0]   tx_level,
    output logic [PTR_W:0]   rx_level,
    output logic             timeout_err,
    input  logic             clr_err
);
    localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, GAP = 2'd3;
    localparam logic [1:0] POST_WAIT = GAP_CYCLES > 0 ? GAP : IDLE;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [1:0]       state;
    logic [7:0]       tx_mem [DEPTH];
    logic [7:0]       rx_mem [DEPTH];
    logic [PTR_W-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [TW-1:0]    to_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             tx_push, tx_pop, rx_push, rx_pop, abort;

    // Launch requires a free RX slot, so the single in-flight byte can always land.
    always_comb begin
        in_ready  = tx_level != FULL;
        out_valid = rx_level != '0;
        out_data  = rx_mem[rx_rd];
        m_start   = state == LAUNCH;
        busy      = state != IDLE || tx_level != '0;
        tx_push   = in_valid && in_ready;
        tx_pop    = state == IDLE && tx_level != '0 && rx_level != FULL;
        rx_pop    = out_valid && out_ready;
        rx_push   = state == WAIT && m_tx_valid;
        abort     = state == WAIT && !m_tx_valid && to_cnt == TO_LAST;
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= in_data;
        if (rx_push) rx_mem[rx_wr] <= m_rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tx_wr       <= '0;
            tx_rd       <= '0;
            rx_wr       <= '0;
            rx_rd       <= '0;
            tx_level    <= '0;
            rx_level    <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            m_tx_data   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop) tx_rd <= tx_rd + 1'b1;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop) rx_rd <= rx_rd + 1'b1;
            if (tx_push != tx_pop) tx_level <= tx_push ? tx_level + 1'b1 : tx_level - 1'b1;
            if (rx_push != rx_pop) rx_level <= rx_push ? rx_level + 1'b1 : rx_level - 1'b1;
            timeout_err <= abort || (timeout_err && !clr_err);
            case (state)
                IDLE: if (tx_pop) begin
                    m_tx_data <= tx_mem[tx_rd];
                    state     <= LAUNCH;
                end
                LAUNCH: begin
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: if (rx_push || abort) begin
                    gap_cnt <= '0;
                    state   <= POST_WAIT;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
                default: if (gap_cnt == GAP_LAST) state <= IDLE;
                         else gap_cnt <= gap_cnt + 1'b1;
            endcase
        end
    end
endmodule
